// File: rtl/pma_pkg.sv
// rtl/pma_pkg.sv - shared types, default widths and width helper for pattern_match_arbiter
package pma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pma_state_e;

  localparam int PMA_NUM_REQ = 4;
  localparam int PMA_DATA_W  = 8;
  localparam int PMA_PAT_W   = 4;
  localparam int PMA_CNT_W   = 4;

  function automatic int pma_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_match_arbiter_if.sv
// rtl/pattern_match_arbiter_if.sv - requester/response bus of the shared pattern detector
interface pattern_match_arbiter_if
  import pma_pkg::*;
#(
  parameter int NUM_REQ = PMA_NUM_REQ,
  parameter int DATA_W  = PMA_DATA_W,
  parameter int PAT_W   = PMA_PAT_W,
  parameter int CNT_W   = PMA_CNT_W
);
  localparam int ID_W = pma_id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*PAT_W-1:0]  req_pattern;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [CNT_W-1:0]          resp_count;
  logic                      resp_ready;

  modport master (
    output req_valid, req_data, req_pattern, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_count
  );

  modport slave (
    input  req_valid, req_data, req_pattern, resp_ready,
    output req_ready, resp_valid, resp_id, resp_count
  );

endinterface

// File: rtl/pat_seq_detect.sv
// rtl/pat_seq_detect.sv - serial pattern detector with registered match
// PMA_NONOVERLAP_EN: restart the fill after each match so matches never share bits.
module pat_seq_detect
  import pma_pkg::*;
#(
  parameter int PAT_W = PMA_PAT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  // A match is only valid once PAT_W bits of the current word have been seen.
  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift_en) begin
      win_d = (win_q << 1) | PAT_W'(bit_in);
      if (fill_q != FULL) begin
        fill_d = fill_q + 1'b1;
      end
      match_d = (fill_d == FULL) && (win_d == pattern);
`ifdef PMA_NONOVERLAP_EN
      if (match_d) begin
        fill_d = '0;
      end
`endif
    end
  end

  assign match = match_q;

endmodule

// File: rtl/pattern_match_arbiter.sv
// rtl/pattern_match_arbiter.sv - round-robin front end sharing one serial pattern detector
// Overlap behaviour of the detector selected by PMA_NONOVERLAP_EN.
module pattern_match_arbiter
  import pma_pkg::*;
#(
  parameter int NUM_REQ = PMA_NUM_REQ,
  parameter int DATA_W  = PMA_DATA_W,
  parameter int PAT_W   = PMA_PAT_W,
  parameter int CNT_W   = PMA_CNT_W
) (
  input  logic                    clk,
  input  logic                    n_rst,
  pattern_match_arbiter_if.slave  bus
);
  localparam int ID_W = pma_id_w(NUM_REQ);
  localparam int BC_W = pma_id_w(DATA_W);
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_W - 1);

  pma_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx, grant_next;
  logic [ID_W:0]     scan;
  logic              accept;
  logic              det_shift;
  logic              det_match;

  // Scan requesters starting at the rr pointer; modulo done by one conditional subtract.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_q} + (ID_W+1)'(i);
      if (scan >= NUM_REQ_X) scan = scan - NUM_REQ_X;
      if (!grant_found && bus.req_valid[scan[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[ID_W-1:0];
      end
    end
    scan = {1'b0, grant_idx} + (ID_W+1)'(1);
    if (scan >= NUM_REQ_X) scan = scan - NUM_REQ_X;
    grant_next = scan[ID_W-1:0];
  end

  assign accept    = n_rst && (state_q == IDLE) && grant_found;
  assign det_shift = (state_q == SHIFT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      data_q    <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      data_q    <= data_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == '0) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d      = rr_q;
    id_d      = id_q;
    data_d    = data_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    if (accept) begin
      data_d    = bus.req_data[grant_idx*DATA_W +: DATA_W];
      pat_d     = bus.req_pattern[grant_idx*PAT_W +: PAT_W];
      id_d      = grant_idx;
      rr_d      = grant_next;
      bit_cnt_d = LAST_BIT;
      cnt_d     = '0;
    end
    if (state_q == SHIFT) begin
      data_d = data_q << 1;
      if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - 1'b1;
    end
    // FLUSH exists so the match registered off the last data bit still lands here.
    if ((state_q == SHIFT || state_q == FLUSH) && det_match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign bus.req_ready  = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_id    = id_q;
  assign bus.resp_count = cnt_q;

  pat_seq_detect #(.PAT_W(PAT_W)) u_detect (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (accept),
    .shift_en (det_shift),
    .bit_in   (data_q[DATA_W-1]),
    .pattern  (pat_q),
    .match    (det_match)
  );

endmodule
